// File: rtl/ball_motion_if.sv
// Control/status bundle between the game controller, ball_motion and the
// collision/render logic. The controller side is the master.
interface ball_motion_if #(
    parameter int CWIDTH = 10,
    parameter int TWIDTH = 24
);
    logic              active;
    logic              load;
    logic [CWIDTH-1:0] x_start;
    logic [CWIDTH-1:0] y_start;
    logic              x_dir_start;
    logic              y_dir_start;
    logic [TWIDTH-1:0] x_threshold;
    logic [TWIDTH-1:0] y_threshold;
    logic [CWIDTH-1:0] x;
    logic [CWIDTH-1:0] y;
    logic              x_dir;
    logic              y_dir;
    logic              x_bounce;
    logic              y_bounce;
    logic              moving;

    modport master (
        output active, load, x_start, y_start, x_dir_start, y_dir_start,
               x_threshold, y_threshold,
        input  x, y, x_dir, y_dir, x_bounce, y_bounce, moving
    );

    modport slave (
        input  active, load, x_start, y_start, x_dir_start, y_dir_start,
               x_threshold, y_threshold,
        output x, y, x_dir, y_dir, x_bounce, y_bounce, moving
    );
endinterface

// File: rtl/ball_motion.sv
// Two-axis pong ball mover: each axis steps at its own programmable period
// and reflects off the playfield edges with a one-cycle bounce pulse.
module ball_motion #(
    parameter int CWIDTH = 10,
    parameter int TWIDTH = 24,
    parameter int XMAX   = 639,
    parameter int YMAX   = 479
) (
    input  logic          clock,
    input  logic          reset_n,
    ball_motion_if.slave  bus
);

    typedef enum logic {IDLE, RUN} state_e;

    localparam logic [CWIDTH-1:0] XMAX_C = CWIDTH'(XMAX);
    localparam logic [CWIDTH-1:0] YMAX_C = CWIDTH'(YMAX);
    localparam logic [CWIDTH-1:0] XRST_C = CWIDTH'(XMAX / 2);
    localparam logic [CWIDTH-1:0] YRST_C = CWIDTH'(YMAX / 2);

    state_e            state_q, state_d;
    logic [CWIDTH-1:0] x_q, x_d, y_q, y_d;
    logic              x_dir_q, x_dir_d, y_dir_q, y_dir_d;
    logic [TWIDTH-1:0] x_timer_q, x_timer_d, y_timer_q, y_timer_d;
    logic              x_bounce_q, x_bounce_d, y_bounce_q, y_bounce_d;
    logic              moving_q, moving_d;

    // One step along an axis; hitting an edge reflects to the neighbouring cell.
    function automatic void step_axis(
        input  logic [CWIDTH-1:0] coord,
        input  logic              dir,
        input  logic [CWIDTH-1:0] lim,
        output logic [CWIDTH-1:0] coord_n,
        output logic              dir_n,
        output logic              bounce
    );
        coord_n = coord;
        dir_n   = dir;
        bounce  = 1'b0;
        if (dir) begin
            if (coord < lim) begin
                coord_n = coord + CWIDTH'(1);
            end else begin
                dir_n   = 1'b0;
                coord_n = lim - CWIDTH'(1);
                bounce  = 1'b1;
            end
        end else begin
            if (coord != '0) begin
                coord_n = coord - CWIDTH'(1);
            end else begin
                dir_n   = 1'b1;
                coord_n = CWIDTH'(1);
                bounce  = 1'b1;
            end
        end
    endfunction

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        x_dir_d    = x_dir_q;
        y_dir_d    = y_dir_q;
        x_timer_d  = x_timer_q;
        y_timer_d  = y_timer_q;
        x_bounce_d = 1'b0;
        y_bounce_d = 1'b0;

        case (state_q)
            IDLE:    if (bus.active && !bus.load) state_d = RUN;
            RUN:     if (!bus.active) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // The cycle that enters RUN does not count; only RUN with active high does.
        if (bus.load) begin
            x_d       = (bus.x_start > XMAX_C) ? XMAX_C : bus.x_start;
            y_d       = (bus.y_start > YMAX_C) ? YMAX_C : bus.y_start;
            x_dir_d   = bus.x_dir_start;
            y_dir_d   = bus.y_dir_start;
            x_timer_d = '0;
            y_timer_d = '0;
        end else if (state_q == RUN && bus.active) begin
            if (x_timer_q >= bus.x_threshold) begin
                x_timer_d = '0;
                step_axis(x_q, x_dir_q, XMAX_C, x_d, x_dir_d, x_bounce_d);
            end else begin
                x_timer_d = x_timer_q + TWIDTH'(1);
            end
            if (y_timer_q >= bus.y_threshold) begin
                y_timer_d = '0;
                step_axis(y_q, y_dir_q, YMAX_C, y_d, y_dir_d, y_bounce_d);
            end else begin
                y_timer_d = y_timer_q + TWIDTH'(1);
            end
        end

        moving_d = (state_d == RUN);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            x_q        <= XRST_C;
            y_q        <= YRST_C;
            x_dir_q    <= 1'b1;
            y_dir_q    <= 1'b1;
            x_timer_q  <= '0;
            y_timer_q  <= '0;
            x_bounce_q <= 1'b0;
            y_bounce_q <= 1'b0;
            moving_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            x_dir_q    <= x_dir_d;
            y_dir_q    <= y_dir_d;
            x_timer_q  <= x_timer_d;
            y_timer_q  <= y_timer_d;
            x_bounce_q <= x_bounce_d;
            y_bounce_q <= y_bounce_d;
            moving_q   <= moving_d;
        end
    end

    assign bus.x        = x_q;
    assign bus.y        = y_q;
    assign bus.x_dir    = x_dir_q;
    assign bus.y_dir    = y_dir_q;
    assign bus.x_bounce = x_bounce_q;
    assign bus.y_bounce = y_bounce_q;
    assign bus.moving   = moving_q;

endmodule

// File: tb/tb_ball_motion.sv
// Scoreboard bench for ball_motion: directed serves, bounces, corner hit,
// pause/resume and load/reset priority with hand-computed expectations.
module tb_ball_motion;

    typedef struct {
        int    cyc;
        string name;
        int    x;
        int    y;
        int    xd;
        int    yd;
        int    xb;
        int    yb;
        int    mv;
    } exp_t;

    logic clock = 1'b0;
    logic reset_n;
    int   edgeCount = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t expQ[$];

    ball_motion_if #(.CWIDTH(11), .TWIDTH(24)) bus ();

    ball_motion #(.CWIDTH(11), .TWIDTH(24), .XMAX(639), .YMAX(479)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    always @(posedge clock) edgeCount <= edgeCount + 1;

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic applyStimulus(input logic act, input logic ld,
                                 input int xs, input int ys,
                                 input logic xds, input logic yds,
                                 input int xt, input int yt);
        bus.active      = act;
        bus.load        = ld;
        bus.x_start     = 11'(xs);
        bus.y_start     = 11'(ys);
        bus.x_dir_start = xds;
        bus.y_dir_start = yds;
        bus.x_threshold = 24'(xt);
        bus.y_threshold = 24'(yt);
    endtask

    // Expected state after the most recent edge; -1 marks a field as unchecked.
    task automatic checkOutput(input string name, input int x, input int y,
                               input int xd, input int yd, input int xb,
                               input int yb, input int mv);
        exp_t e;
        e.cyc = edgeCount; e.name = name;
        e.x = x; e.y = y; e.xd = xd; e.yd = yd; e.xb = xb; e.yb = yb; e.mv = mv;
        expQ.push_back(e);
    endtask

    task automatic compareField(input string name, input string field,
                                input int actual, input int expected);
        if (expected >= 0) begin
            checks++;
            if (actual != expected) begin
                errors++;
                $display("[TB] FAIL %s.%s actual=%0d expected=%0d", name, field, actual, expected);
            end
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            #2;
            while (expQ.size() > 0 && expQ[0].cyc <= edgeCount) begin
                e = expQ.pop_front();
                if (e.cyc < edgeCount) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL %s missed sample actual_cycle=%0d expected_cycle=%0d",
                             e.name, edgeCount, e.cyc);
                end else begin
                    compareField(e.name, "x",        int'(bus.x),        e.x);
                    compareField(e.name, "y",        int'(bus.y),        e.y);
                    compareField(e.name, "x_dir",    int'(bus.x_dir),    e.xd);
                    compareField(e.name, "y_dir",    int'(bus.y_dir),    e.yd);
                    compareField(e.name, "x_bounce", int'(bus.x_bounce), e.xb);
                    compareField(e.name, "y_bounce", int'(bus.y_bounce), e.yb);
                    compareField(e.name, "moving",   int'(bus.moving),   e.mv);
                end
            end
        end
    end

    initial begin : stimulus
        reset_n = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        tick(2);
        checkOutput("reset", 319, 239, 1, 1, 0, 0, 0);

        $display("[TB] rate test");
        reset_n = 1'b1;
        applyStimulus(1, 1, 100, 100, 1, 1, 3, 0);
        tick(1);
        checkOutput("rate_load", 100, 100, 1, 1, 0, 0, 0);
        applyStimulus(1, 0, 100, 100, 1, 1, 3, 0);
        tick(1);
        checkOutput("rate_enter_run", 100, 100, -1, -1, 0, 0, 1);
        tick(1);
        checkOutput("rate_first", 100, 101, -1, -1, 0, 0, 1);
        tick(39);
        checkOutput("rate_40", 110, 140, 1, 1, 0, 0, 1);

        $display("[TB] high-edge bounce");
        applyStimulus(1, 1, 638, 200, 1, 1, 0, 7);
        tick(1);
        checkOutput("bhi_load", 638, 200, 1, 1, 0, 0, 1);
        applyStimulus(1, 0, 638, 200, 1, 1, 0, 7);
        tick(1);
        checkOutput("bhi_max", 639, 200, 1, 1, 0, 0, -1);
        tick(1);
        checkOutput("bhi_reflect", 638, 200, 0, 1, 1, 0, -1);
        tick(1);
        checkOutput("bhi_after", 637, 200, 0, 1, 0, 0, -1);

        $display("[TB] low-edge bounce");
        applyStimulus(1, 1, 1, 200, 0, 1, 0, 7);
        tick(1);
        checkOutput("blo_load", 1, 200, 0, 1, 0, 0, -1);
        applyStimulus(1, 0, 1, 200, 0, 1, 0, 7);
        tick(1);
        checkOutput("blo_zero", 0, -1, 0, -1, 0, -1, -1);
        tick(1);
        checkOutput("blo_reflect", 1, -1, 1, -1, 1, -1, -1);
        tick(1);
        checkOutput("blo_after", 2, -1, 1, -1, 0, -1, -1);

        $display("[TB] corner");
        applyStimulus(1, 1, 639, 0, 1, 0, 0, 0);
        tick(1);
        checkOutput("corner_load", 639, 0, 1, 0, 0, 0, 1);
        applyStimulus(1, 0, 639, 0, 1, 0, 0, 0);
        tick(1);
        checkOutput("corner_hit", 638, 1, 0, 1, 1, 1, 1);
        tick(1);
        checkOutput("corner_after", 637, 2, 0, 1, 0, 0, 1);

        $display("[TB] pause/resume");
        applyStimulus(1, 1, 300, 100, 1, 1, 9, 1000);
        tick(1);
        checkOutput("pause_load", 300, 100, 1, 1, 0, 0, 1);
        applyStimulus(1, 0, 300, 100, 1, 1, 9, 1000);
        tick(5);
        checkOutput("pause_t5", 300, 100, -1, -1, 0, 0, 1);
        applyStimulus(0, 0, 300, 100, 1, 1, 9, 1000);
        tick(1);
        checkOutput("pause_stop", 300, 100, -1, -1, 0, 0, 0);
        tick(19);
        checkOutput("pause_hold", 300, 100, 1, 1, 0, 0, 0);
        applyStimulus(1, 0, 300, 100, 1, 1, 9, 1000);
        tick(1);
        checkOutput("resume_run", 300, 100, -1, -1, 0, 0, 1);
        tick(4);
        checkOutput("resume_pre", 300, -1, -1, -1, 0, -1, 1);
        tick(1);
        checkOutput("resume_step", 301, 100, 1, 1, 0, 0, 1);

        $display("[TB] load clamp and reset priority");
        applyStimulus(1, 1, 2000, 700, 1, 1, 0, 0);
        tick(1);
        checkOutput("clamp", 639, 479, 1, 1, 0, 0, -1);
        applyStimulus(1, 1, 5, 5, 0, 0, 0, 0);
        reset_n = 1'b0;
        tick(1);
        checkOutput("reset_over_load", 319, 239, 1, 1, 0, 0, 0);

        for (int i = 0; i < 10 && expQ.size() > 0; i++) tick(1);
        if (expQ.size() > 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain pending=%0d expected=0", expQ.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
